// File: rtl/bcd_pkg.sv
// Shared BCD helpers for the counter bank: digit constants, single-digit
// step functions returning {carry, digit}, multi-digit compare and FSM states.
package bcd_pkg;

   localparam int BCD_W      = 4;
   localparam int MAX_DIGITS = 8;

   localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
   localparam logic [BCD_W-1:0] DIGIT_MIN = 4'd0;

   typedef logic [BCD_W*MAX_DIGITS-1:0] bcd_word_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_REPEAT
   } press_state_t;

   function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] d);
      return (d >= DIGIT_MAX) ? {1'b1, DIGIT_MIN} : {1'b0, d + 4'd1};
   endfunction

   function automatic logic [BCD_W:0] bcd_dec(input logic [BCD_W-1:0] d);
      return (d == DIGIT_MIN) ? {1'b1, DIGIT_MAX} : {1'b0, d - 4'd1};
   endfunction

   // Valid BCD orders the same as binary, so a plain compare is exact.
   function automatic logic bcd_le(input bcd_word_t a, input bcd_word_t b);
      return a <= b;
   endfunction

endpackage

// File: rtl/press_repeat_fsm.sv
// One digit's press / auto-repeat engine: a step request on press, one after
// REPEAT_DELAY ticks of holding, then one every REPEAT_PERIOD ticks.
module press_repeat_fsm
   import bcd_pkg::*;
#(
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100,
   parameter int TMR_W         = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic level,
   output logic set_pending
);

   localparam logic [TMR_W-1:0] DELAY_LD  = TMR_W'(REPEAT_DELAY);
   localparam logic [TMR_W-1:0] PERIOD_LD = TMR_W'(REPEAT_PERIOD);

   press_state_t     state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      set_pending = 1'b0;
      if (!level) begin
         state_nxt = S_IDLE;
         timer_nxt = '0;
      end else begin
         case (state)
            S_IDLE: begin
               set_pending = 1'b1;
               timer_nxt   = DELAY_LD;
               state_nxt   = S_HOLD;
            end
            S_HOLD, S_REPEAT: begin
               // Expiry is detected on the tick that would take the timer to 0.
               if (tick) begin
                  if (timer <= TMR_W'(1)) begin
                     set_pending = 1'b1;
                     timer_nxt   = PERIOD_LD;
                     state_nxt   = S_REPEAT;
                  end else begin
                     timer_nxt = timer - TMR_W'(1);
                  end
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bcd_counter_bank.sv
// Multi-digit BCD counter: per-digit press/repeat engines feed a single-step
// arbiter driving a carry-chain or per-digit datapath with a min/max window.
module bcd_counter_bank
   import bcd_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int TICK_DIV      = 1000,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100,
   parameter int TMR_W         = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DIGITS-1:0]     inc_req,
   input  logic                  up_dn,
   input  logic                  carry_en,
   input  logic                  limit_en,
   input  logic                  load_max,
   input  logic                  load_min,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   count_out,
   output logic [4*DIGITS-1:0]   max_out,
   output logic [4*DIGITS-1:0]   min_out,
   output logic                  wrap_pulse,
   output logic                  busy
);

   localparam int W  = BCD_W * DIGITS;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] ALL_NINES = {DIGITS{DIGIT_MAX}};

   logic [PW-1:0]     presc;
   logic              tick;
   logic [W-1:0]      count_r, max_r, min_r, step_cnt;
   logic [DIGITS-1:0] pending, set_pend, grant;
   logic              wrap_r, step_wrap, lim_ok;

   assign tick   = (presc == PW'(TICK_DIV - 1));
   assign grant  = pending & (~pending + DIGITS'(1));
   assign lim_ok = bcd_le(bcd_word_t'(min_r), bcd_word_t'(max_r));

   for (genvar j = 0; j < DIGITS; j++) begin : g_digit
      press_repeat_fsm #(
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .TMR_W         (TMR_W)
      ) u_fsm (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick        (tick),
         .level       (inc_req[j]),
         .set_pending (set_pend[j])
      );
   end

   always_comb begin : p_step
      logic             c;
      logic [BCD_W:0]   r;
      logic [BCD_W-1:0] d, mx, mn;
      step_cnt  = count_r;
      step_wrap = 1'b0;
      c  = 1'b0;
      r  = '0;
      d  = '0;
      mx = '0;
      mn = '0;
      if (carry_en) begin
         if (limit_en && lim_ok && up_dn &&
             bcd_le(bcd_word_t'(max_r), bcd_word_t'(count_r))) begin
            step_cnt  = min_r;
            step_wrap = 1'b1;
         end else if (limit_en && lim_ok && !up_dn &&
                      bcd_le(bcd_word_t'(count_r), bcd_word_t'(min_r))) begin
            step_cnt  = max_r;
            step_wrap = 1'b1;
         end else begin
            // Ripple starts at the granted digit; digits below are untouched.
            for (int i = 0; i < DIGITS; i++) begin
               if (grant[i] || c) begin
                  r = up_dn ? bcd_inc(count_r[BCD_W*i +: BCD_W])
                            : bcd_dec(count_r[BCD_W*i +: BCD_W]);
                  step_cnt[BCD_W*i +: BCD_W] = r[BCD_W-1:0];
                  c = r[BCD_W];
               end
            end
            if (c) begin
               step_cnt  = up_dn ? '0 : ALL_NINES;
               step_wrap = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            if (grant[i]) begin
               d  = count_r[BCD_W*i +: BCD_W];
               mx = max_r[BCD_W*i +: BCD_W];
               mn = min_r[BCD_W*i +: BCD_W];
               if (limit_en && (mn <= mx) && (up_dn ? (d >= mx) : (d <= mn))) begin
                  step_cnt[BCD_W*i +: BCD_W] = up_dn ? mn : mx;
                  step_wrap = 1'b1;
               end else begin
                  r = up_dn ? bcd_inc(d) : bcd_dec(d);
                  step_cnt[BCD_W*i +: BCD_W] = r[BCD_W-1:0];
                  step_wrap = r[BCD_W];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc   <= '0;
         count_r <= '0;
         max_r   <= ALL_NINES;
         min_r   <= '0;
         pending <= '0;
         wrap_r  <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         // Loads see the register value, i.e. the pre-step / pre-clear count.
         if (load_max) max_r <= count_r;
         if (load_min) min_r <= count_r;
         if (clear) begin
            count_r <= (limit_en && lim_ok) ? min_r : '0;
            pending <= '0;
            wrap_r  <= 1'b0;
         end else begin
            pending <= (pending | set_pend) & ~grant;
            if (|grant) count_r <= step_cnt;
            wrap_r <= (|grant) & step_wrap;
         end
      end
   end

   assign count_out  = count_r;
   assign max_out    = max_r;
   assign min_out    = min_r;
   assign wrap_pulse = wrap_r;
   assign busy       = |pending;

endmodule

// File: tb/tb_bcd_counter_bank.sv
// Bench for bcd_counter_bank: directed vector table, hand sequences for the
// multi-cycle cases, then random stimulus against a decimal reference model.
module tb_bcd_counter_bank;

   localparam int DIGITS = 4;
   localparam int TDIV   = 4;
   localparam int RD     = 3;
   localparam int RP     = 2;
   localparam int W      = 4 * DIGITS;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DIGITS-1:0] inc_req = '0;
   logic              up_dn = 1'b1, carry_en = 1'b0, limit_en = 1'b0;
   logic              load_max = 1'b0, load_min = 1'b0, clear = 1'b0;
   logic [W-1:0]      count_out, max_out, min_out;
   logic              wrap_pulse, busy;

   bcd_counter_bank #(
      .DIGITS(DIGITS), .TICK_DIV(TDIV), .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP), .TMR_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .inc_req(inc_req), .up_dn(up_dn),
      .carry_en(carry_en), .limit_en(limit_en), .load_max(load_max),
      .load_min(load_min), .clear(clear), .count_out(count_out),
      .max_out(max_out), .min_out(min_out), .wrap_pulse(wrap_pulse),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state: counts held as plain decimal integers.
   int m_cnt, m_max, m_min, m_presc;
   bit m_wrap;
   bit [DIGITS-1:0] m_pend;
   bit m_held [DIGITS];
   int m_ticks [DIGITS];

   function automatic int p10(int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic int dig(int v, int i);
      return (v / p10(i)) % 10;
   endfunction

   function automatic logic [W-1:0] to_bcd(int v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(dig(v, i));
      return r;
   endfunction

   task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      bit [DIGITS-1:0] set, np;
      bit tick, nw, valid, dv;
      int nc, g, hi, lo, d, mx, mn, nd;
      if (!rst_n) begin
         m_cnt = 0; m_max = p10(DIGITS) - 1; m_min = 0; m_presc = 0;
         m_wrap = 0; m_pend = '0;
         for (int j = 0; j < DIGITS; j++) begin m_held[j] = 0; m_ticks[j] = 0; end
         return;
      end
      tick = (m_presc == TDIV - 1);
      set = '0;
      for (int j = 0; j < DIGITS; j++) begin
         if (!inc_req[j]) m_held[j] = 0;
         else if (!m_held[j]) begin
            set[j] = 1; m_held[j] = 1; m_ticks[j] = 0;
         end else if (tick) begin
            m_ticks[j]++;
            if (m_ticks[j] >= RD && (m_ticks[j] - RD) % RP == 0) set[j] = 1;
         end
      end
      nc = m_cnt; nw = 0; valid = (m_min <= m_max);
      if (clear) begin
         nc = (limit_en && valid) ? m_min : 0;
         np = '0;
      end else begin
         g = -1;
         for (int j = DIGITS - 1; j >= 0; j--) if (m_pend[j]) g = j;
         if (g >= 0) begin
            if (carry_en) begin
               if (limit_en && valid && up_dn && m_cnt >= m_max) begin nc = m_min; nw = 1; end
               else if (limit_en && valid && !up_dn && m_cnt <= m_min) begin nc = m_max; nw = 1; end
               else begin
                  hi = m_cnt / p10(g); lo = m_cnt % p10(g);
                  if (up_dn) begin
                     if (hi + 1 == p10(DIGITS - g)) begin nc = 0; nw = 1; end
                     else nc = (hi + 1) * p10(g) + lo;
                  end else begin
                     if (hi == 0) begin nc = p10(DIGITS) - 1; nw = 1; end
                     else nc = (hi - 1) * p10(g) + lo;
                  end
               end
            end else begin
               d = dig(m_cnt, g); mx = dig(m_max, g); mn = dig(m_min, g); dv = (mn <= mx);
               if (limit_en && dv && up_dn && d >= mx) begin nd = mn; nw = 1; end
               else if (limit_en && dv && !up_dn && d <= mn) begin nd = mx; nw = 1; end
               else if (up_dn) begin nd = (d == 9) ? 0 : d + 1; nw = (d == 9); end
               else begin nd = (d == 0) ? 9 : d - 1; nw = (d == 0); end
               nc = m_cnt + (nd - d) * p10(g);
            end
         end
         np = m_pend | set;
         if (g >= 0) np[g] = 0;
      end
      if (load_max) m_max = m_cnt;
      if (load_min) m_min = m_cnt;
      m_cnt = nc; m_wrap = nw; m_pend = np;
      m_presc = (m_presc + 1) % TDIV;
   endtask

   // Advance one clock with the inputs currently driven, then compare all outputs.
   task automatic cyc();
      model_update();
      @(negedge clk);
      chk("m_count", count_out, to_bcd(m_cnt));
      chk("m_max", max_out, to_bcd(m_max));
      chk("m_min", min_out, to_bcd(m_min));
      chk("m_wrap", W'(wrap_pulse), W'(m_wrap));
      chk("m_busy", W'(busy), W'(m_pend != '0));
   endtask

   typedef struct {
      int dig; bit up; bit cen; bit len; bit lmax; bit lmin; bit clr;
      logic [W-1:0] exp_cnt; bit exp_wrap;
   } vec_t;

   vec_t tbl[$];
   int   wraps, busy_cnt;

   initial begin
      //               dig up cen len lmax lmin clr  count    wrap
      tbl.push_back('{ 0, 0, 1, 0, 0, 0, 0, 16'h9999, 1});
      tbl.push_back('{ 0, 1, 1, 0, 0, 0, 0, 16'h0000, 1});
      tbl.push_back('{ 0, 0, 1, 0, 0, 0, 0, 16'h9999, 1});
      tbl.push_back('{ 2, 1, 0, 0, 0, 0, 0, 16'h9099, 1});
      tbl.push_back('{ 3, 1, 0, 0, 0, 0, 0, 16'h0099, 1});
      tbl.push_back('{ 0, 1, 1, 0, 0, 0, 0, 16'h0100, 0});
      tbl.push_back('{ 0, 0, 1, 0, 0, 0, 0, 16'h0099, 0});
      tbl.push_back('{ 1, 1, 1, 0, 0, 0, 0, 16'h0109, 0});
      tbl.push_back('{ 1, 0, 0, 0, 0, 0, 0, 16'h0199, 1});
      tbl.push_back('{ 3, 0, 1, 0, 0, 0, 0, 16'h9999, 1});
      tbl.push_back('{ 3, 1, 1, 0, 0, 0, 0, 16'h0000, 1});
      tbl.push_back('{ 1, 1, 1, 0, 0, 0, 0, 16'h0010, 0});
      tbl.push_back('{-1, 1, 1, 0, 0, 1, 0, 16'h0010, 0});
      tbl.push_back('{ 0, 1, 1, 0, 0, 0, 0, 16'h0011, 0});
      tbl.push_back('{ 0, 1, 1, 0, 0, 0, 0, 16'h0012, 0});
      tbl.push_back('{ 0, 1, 1, 0, 0, 0, 0, 16'h0013, 0});
      tbl.push_back('{ 0, 1, 1, 0, 0, 0, 0, 16'h0014, 0});
      tbl.push_back('{ 0, 1, 1, 0, 0, 0, 0, 16'h0015, 0});
      tbl.push_back('{-1, 1, 1, 0, 1, 0, 0, 16'h0015, 0});
      tbl.push_back('{ 0, 1, 1, 1, 0, 0, 0, 16'h0010, 1});
      tbl.push_back('{ 0, 0, 1, 1, 0, 0, 0, 16'h0015, 1});
      tbl.push_back('{ 0, 0, 1, 1, 0, 0, 0, 16'h0014, 0});
      tbl.push_back('{ 0, 1, 0, 1, 0, 0, 0, 16'h0015, 0});
      tbl.push_back('{ 0, 1, 0, 1, 0, 0, 0, 16'h0010, 1});
      tbl.push_back('{ 0, 0, 0, 1, 0, 0, 0, 16'h0015, 1});
      tbl.push_back('{ 2, 1, 0, 1, 0, 0, 0, 16'h0015, 1});
      tbl.push_back('{-1, 1, 1, 1, 0, 0, 1, 16'h0010, 0});
      tbl.push_back('{-1, 1, 1, 0, 0, 0, 1, 16'h0000, 0});

      // Reset
      @(negedge clk);
      repeat (3) cyc();
      chk("rst_count", count_out, 16'h0000);
      chk("rst_max", max_out, 16'h9999);
      chk("rst_min", min_out, 16'h0000);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_wrap", W'(wrap_pulse), W'(0));
      rst_n = 1'b1;
      cyc();
      chk("rel_count", count_out, 16'h0000);
      chk("rel_max", max_out, 16'h9999);

      foreach (tbl[k]) begin
         inc_req = '0;
         if (tbl[k].dig >= 0) inc_req[tbl[k].dig] = 1'b1;
         up_dn = tbl[k].up; carry_en = tbl[k].cen; limit_en = tbl[k].len;
         load_max = tbl[k].lmax; load_min = tbl[k].lmin; clear = tbl[k].clr;
         cyc();
         inc_req = '0; load_max = 0; load_min = 0; clear = 0;
         cyc();
         chk($sformatf("vec%0d_count", k), count_out, tbl[k].exp_cnt);
         chk($sformatf("vec%0d_wrap", k), W'(wrap_pulse), W'(tbl[k].exp_wrap));
      end
      chk("win_max", max_out, 16'h0015);
      chk("win_min", min_out, 16'h0010);

      // Hold digit 1 for 30 ticks: 15 steps, one 9->0 wrap.
      up_dn = 1; carry_en = 0; limit_en = 0; wraps = 0;
      inc_req = 4'b0010;
      repeat (121) begin cyc(); if (wrap_pulse) wraps++; end
      inc_req = '0;
      repeat (3) begin cyc(); if (wrap_pulse) wraps++; end
      chk("hold_count", count_out, 16'h0050);
      chk("hold_wraps", W'(wraps), W'(1));

      // Two digits requested together: lowest first, busy for two cycles.
      clear = 1; cyc(); clear = 0;
      inc_req = 4'b0101; busy_cnt = 0;
      cyc();
      chk("arb_c1_count", count_out, 16'h0000);
      if (busy) busy_cnt++;
      inc_req = '0;
      cyc();
      chk("arb_c2_count", count_out, 16'h0001);
      if (busy) busy_cnt++;
      cyc();
      chk("arb_c3_count", count_out, 16'h0101);
      if (busy) busy_cnt++;
      chk("arb_busy_cycles", W'(busy_cnt), W'(2));

      // Clear while digit 3 is pending, window valid.
      limit_en = 1; carry_en = 1;
      inc_req = 4'b1000; cyc();
      inc_req = '0; clear = 1; cyc();
      clear = 0;
      chk("clr_count", count_out, 16'h0010);
      chk("clr_busy", W'(busy), W'(0));
      chk("clr_wrap", W'(wrap_pulse), W'(0));
      cyc();
      chk("clr_after", count_out, 16'h0010);

      // Load coinciding with a step captures the pre-step count.
      limit_en = 0;
      inc_req = 4'b0001; cyc();
      inc_req = '0; load_max = 1; cyc();
      load_max = 0;
      chk("ldstep_count", count_out, 16'h0011);
      chk("ldstep_max", max_out, 16'h0010);

      // Reset mid-hold: a still-held button is a new press after release.
      carry_en = 0;
      inc_req = 4'b0001;
      repeat (6) cyc();
      rst_n = 0;
      repeat (2) cyc();
      chk("rsthold_count", count_out, 16'h0000);
      rst_n = 1;
      repeat (3) cyc();
      chk("rsthold_new", count_out, 16'h0001);
      inc_req = '0;
      cyc();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         for (int j = 0; j < DIGITS; j++)
            if ($urandom_range(15) == 0) inc_req[j] = ~inc_req[j];
         if ($urandom_range(31) == 0) up_dn = ~up_dn;
         if ($urandom_range(63) == 0) carry_en = ~carry_en;
         if ($urandom_range(63) == 0) limit_en = ~limit_en;
         load_max = ($urandom_range(39) == 0);
         load_min = ($urandom_range(39) == 0);
         clear    = ($urandom_range(49) == 0);
         rst_n    = ($urandom_range(799) != 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_counter_bank.md
Name: bcd_counter_bank

Overview:
Parametrised multi-digit BCD counter core, the successor to the current per-digit counter array. Per-digit step requests come from already-synchronised active-high button levels. Features:
- press/auto-repeat engine per digit
- single-step arbitration across digits
- optional decimal carry chain
- programmable min/max window with wrap
- capture of the current count into the limit registers

Feeds the display shifter via count_out.

Parameters:
DIGITS, 4, number of BCD digits (1..8)
TICK_DIV, 1000, clk cycles per timing tick (1 ms at 1 MHz)
REPEAT_DELAY, 500, ticks a button must be held before auto-repeat starts
REPEAT_PERIOD, 100, ticks between auto-repeat steps
TMR_W, 10, width of per-digit tick timer; must hold REPEAT_DELAY

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
inc_req  in  DIGITS  held-level step request per digit, active high, already synchronised
up_dn  in  1  1 = count up, 0 = count down
carry_en  in  1  1 = decimal carry/borrow ripples to higher digits
limit_en  in  1  1 = apply min/max window
load_max  in  1  capture count_out into max register
load_min  in  1  capture count_out into min register
clear  in  1  synchronous clear of count
count_out  out  4*DIGITS  BCD count, digit j at [4j+3:4j]
max_out  out  4*DIGITS  current max limit
min_out  out  4*DIGITS  current min limit
wrap_pulse  out  1  one-cycle pulse on any wrap/limit reload
busy  out  1  any digit has a pending step

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. While reset is asserted: count_out=0, max_out=all digits 9, min_out=0, wrap_pulse=0, busy=0. Also cleared: all per-digit FSMs to IDLE, pending bits, prescaler, and timers.
- Prescaler: counts 0..TICK_DIV-1; tick is high for one cycle at wrap. It is free-running from reset.
- Per-digit press FSM (states IDLE, HOLD, REPEAT):
  - IDLE: on inc_req[j]=1, set pending[j], load timer=REPEAT_DELAY, go to HOLD.
  - HOLD: timer decrements on tick. At 0, set pending[j], load REPEAT_PERIOD, go to REPEAT.
  - REPEAT: on each timer expiry, set pending[j] and reload REPEAT_PERIOD.
  - From any state, inc_req[j]=0 returns the FSM to IDLE. A pending bit already set is kept.
- Arbitration:
  - At most one step is applied per cycle; the lowest-index pending digit wins. Its pending bit clears when the step is applied.
  - Losers stay pending and are served in later cycles.
  - A pending bit re-set while still pending does not queue a second step.
  - busy = OR of pending.
- Latency: a request arriving in cycle n with no contention updates count_out at the clock edge ending cycle n+1. wrap_pulse is asserted in the same cycle as the updated count.
- Step arithmetic, carry_en=1: ±1 is applied to the decimal value formed by digits j..DIGITS-1, with lower digits unchanged. Carry/borrow ripples through 9→0 / 0→9.
  - Overflow past the top digit wraps the whole count to 0; underflow wraps it to all 9s. Either case pulses wrap_pulse.
- Step arithmetic, carry_en=0: only digit j changes, 9→0 up and 0→9 down. Each such wrap pulses wrap_pulse.
- Limits, limit_en=1, carry_en=1: the window is compared on the full DIGITS-wide value. The limits are valid only when min≤max; otherwise they are ignored.
  - Up step with count≥max loads min.
  - Down step with count≤min loads max.
  - Both pulse wrap_pulse.
  - The result of a normal step is never checked against the window, so a count outside the window returns to it only on a subsequent step.
- Limits, limit_en=1, carry_en=0: the same rule is applied per digit, using the matching min/max digits.
- load_max / load_min: capture count_out one cycle later. If the same cycle also applies a step, the pre-step value is captured. No BCD check is needed because count is always valid BCD.
- clear:
  - Count loads min if limit_en=1 and the limits are valid, else 0.
  - clear overrides any step in that cycle and clears all pending bits.
  - FSM states are kept, so a held button repeats normally afterwards.
  - wrap_pulse stays 0.
- Simultaneous load and clear: the load captures the pre-clear count.
- Reset mid-hold: the FSM returns to IDLE. A button still held after reset release counts as a new press.

Decomposition:
- Shared package/include bcd_pkg:
  - BCD digit width (4)
  - constants DIGIT_MAX=9, DIGIT_MIN=0
  - BCD increment/decrement functions returning {carry, digit}
  - multi-digit compare function
- Sub-module press_repeat_fsm holds one digit's state, timer and pending set. It takes tick and level and outputs set_pending; it is generated DIGITS times.
- The step/limit datapath stays in bcd_counter_bank.

Test Plan:
- Reset, DIGITS=4, TICK_DIV=4, REPEAT_DELAY=3, REPEAT_PERIOD=2, then release reset → count_out=0000, max_out=9999, min_out=0000, busy=0.
- Count at 0099, carry_en=1, up_dn=1, pulse inc_req[0] → 0100 two cycles later. With count at 9999, the same pulse gives 0000 and wrap_pulse=1 for one cycle.
- Hold inc_req[1] for 30 ticks, carry_en=0, up_dn=1 → one step at press, a first repeat after 3 ticks, then every 2 ticks. Total steps = 1+1+(30-3)/2 = 15 (integer division); digit 1 steps 0→9 and wraps back to 0 once.
- Pulse inc_req[0] and inc_req[2] in the same cycle → digit 0 stepped first; digit 2 stepped next cycle; busy high for 2 cycles.
- Limit window: load min=0010 and max=0015 via load_min/load_max, limit_en=1, count at 0015, step digit 0 up → 0010 with wrap_pulse. Down from 0010 → 0015.
- clear while inc_req[3] is pending, with limit_en=1 and min=0010 → count_out=0010, no step applied, busy=0.
